// File: rtl/arm_pkg.sv
// Shared widths, constants and fetch-state encoding for the instruction-fetch slice.
package arm_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned PC_INC  = 4;

    localparam logic [INSTR_W-1:0] HALT_ENC = 32'hD440_0000;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load captures a fetched instruction, clear kills it, otherwise hold.
module ifid_reg import arm_pkg::*; (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            // Only the valid bit matters once the slot is killed.
            valid_q <= 1'b0;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT fetch FSM, redirect and stall handling.
module if_stage import arm_pkg::*; #(
    parameter logic [arm_pkg::ADDR_W-1:0]  RESET_PC = 64'h0,
    parameter logic [arm_pkg::INSTR_W-1:0] HALT_ENC = arm_pkg::HALT_ENC
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        Stall,
    input  logic                        Flush,
    input  logic                        BranchTaken,
    input  logic [arm_pkg::ADDR_W-1:0]  BranchTarget,
    input  logic [arm_pkg::INSTR_W-1:0] Instruction,
    output logic [arm_pkg::ADDR_W-1:0]  Address,
    output logic [arm_pkg::ADDR_W-1:0]  IFID_PC,
    output logic [arm_pkg::INSTR_W-1:0] IFID_Instruction,
    output logic                        IFID_Valid,
    output logic                        Halted,
    output logic                        MisalignErr,
    output logic [31:0]                 FetchCount
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               misalign_q, misalign_d;
    logic [31:0]        count_q, count_d;
    logic               ifid_load, ifid_clear;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  redirect_pc;

    assign pc_next     = pc_q + ADDR_W'(PC_INC);
    assign redirect_pc = {BranchTarget[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        count_d    = count_q;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (BranchTaken) begin
                    pc_d       = redirect_pc;
                    ifid_clear = 1'b1;
                    misalign_d = misalign_q | (BranchTarget[1:0] != 2'b00);
                end else if (Flush) begin
                    ifid_clear = 1'b1;
                    if (!Stall) begin
                        pc_d = pc_next;
                    end
                end else if (!Stall) begin
                    ifid_load = 1'b1;
                    count_d   = count_q + 32'd1;
                    // The halt word itself is issued; fetch then parks on its address.
                    if (Instruction == HALT_ENC) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_next;
                    end
                end
            end
            StHalt: begin
                ifid_clear = 1'b1;
                if (BranchTaken) begin
                    pc_d       = redirect_pc;
                    misalign_d = misalign_q | (BranchTarget[1:0] != 2'b00);
                    state_d    = StRun;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .load_i  (ifid_load),
        .clear_i (ifid_clear),
        .pc_i    (pc_q),
        .instr_i (Instruction),
        .pc_o    (IFID_PC),
        .instr_o (IFID_Instruction),
        .valid_o (IFID_Valid)
    );

    assign Address     = pc_q;
    assign Halted      = (state_q == StHalt);
    assign MisalignErr = misalign_q;
    assign FetchCount  = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with fixed expectations, then random traffic vs a model.
module tb_if_stage;

    localparam logic [31:0] HALT = 32'hD440_0000;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        Stall, Flush, BranchTaken;
    logic [63:0] BranchTarget;
    logic [31:0] Instruction;
    logic [63:0] Address, IFID_PC;
    logic [31:0] IFID_Instruction, FetchCount;
    logic        IFID_Valid, Halted, MisalignErr;

    logic [31:0] mem [256];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    assign Instruction = mem[Address[9:2]];

    if_stage dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .Stall            (Stall),
        .Flush            (Flush),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Instruction      (Instruction),
        .Address          (Address),
        .IFID_PC          (IFID_PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_Valid       (IFID_Valid),
        .Halted           (Halted),
        .MisalignErr      (MisalignErr),
        .FetchCount       (FetchCount)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        Stall = 0; Flush = 0; BranchTaken = 0; BranchTarget = '0;
        #13;
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002;
        mem[2] = 32'hCCCC_0003; mem[3] = 32'hDDDD_0004;
        RESET_N = 1'b0;
        Stall = 0; Flush = 0; BranchTaken = 0; BranchTarget = '0;
        #3;
        n_cmp++;
        if (Address !== 64'h0 || IFID_Valid !== 1'b0 || IFID_PC !== 64'h0 ||
            IFID_Instruction !== 32'h0 || Halted !== 1'b0 || MisalignErr !== 1'b0 ||
            FetchCount !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%h v=%b pc=%h ins=%h h=%b m=%b cnt=%0d, need all zero",
                     Address, IFID_Valid, IFID_PC, IFID_Instruction, Halted, MisalignErr, FetchCount);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        n_cmp++;
        if (Address !== 64'h0 || IFID_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_cycle: addr=%h v=%b, need addr=0 v=0", Address, IFID_Valid);
        end
        tick();
        n_cmp++;
        if (Address !== 64'h4 || IFID_Valid !== 1'b1 || IFID_Instruction !== 32'hAAAA_0001 ||
            IFID_PC !== 64'h0 || FetchCount !== 32'd1) begin
            n_fail++;
            $display("FAIL first_fetch: addr=%h v=%b ins=%h pc=%h cnt=%0d, need 4 1 aaaa0001 0 1",
                     Address, IFID_Valid, IFID_Instruction, IFID_PC, FetchCount);
        end
        tick();
        n_cmp++;
        if (Address !== 64'h8 || IFID_Instruction !== 32'hBBBB_0002 || IFID_PC !== 64'h4) begin
            n_fail++;
            $display("FAIL second_fetch: addr=%h ins=%h pc=%h, need 8 bbbb0002 4",
                     Address, IFID_Instruction, IFID_PC);
        end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (Address !== 64'h8 || IFID_PC !== 64'h4 || IFID_Instruction !== 32'hBBBB_0002 ||
                IFID_Valid !== 1'b1 || FetchCount !== 32'd2) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: addr=%h pc=%h ins=%h v=%b cnt=%0d, need 8 4 bbbb0002 1 2",
                         i, Address, IFID_PC, IFID_Instruction, IFID_Valid, FetchCount);
            end
        end
        Stall = 1'b0;
    endtask

    task automatic test_branch();
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 64'h40;
        tick();
        n_cmp++;
        if (Address !== 64'h40 || IFID_Valid !== 1'b0 || FetchCount !== 32'd2) begin
            n_fail++;
            $display("FAIL branch_over_stall: addr=%h v=%b cnt=%0d, need 40 0 2",
                     Address, IFID_Valid, FetchCount);
        end
        Stall = 1'b0; BranchTaken = 1'b0;
        tick();
        n_cmp++;
        if (IFID_PC !== 64'h40 || IFID_Valid !== 1'b1 || IFID_Instruction !== 32'h1000_0010 ||
            Address !== 64'h44 || FetchCount !== 32'd3) begin
            n_fail++;
            $display("FAIL branch_latch: pc=%h v=%b ins=%h addr=%h cnt=%0d, need 40 1 10000010 44 3",
                     IFID_PC, IFID_Valid, IFID_Instruction, Address, FetchCount);
        end
    endtask

    task automatic test_misalign();
        n_cmp++;
        if (MisalignErr !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_clean: got %b need 0", MisalignErr);
        end
        BranchTaken = 1'b1; BranchTarget = 64'h43;
        tick();
        BranchTaken = 1'b0;
        n_cmp++;
        if (Address !== 64'h40 || MisalignErr !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_set: addr=%h m=%b, need 40 1", Address, MisalignErr);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (MisalignErr !== 1'b1) begin
                n_fail++;
                $display("FAIL misalign_sticky[%0d]: got %b need 1", i, MisalignErr);
            end
        end
    endtask

    task automatic test_flush();
        logic [63:0] a0;
        logic [31:0] c0;
        a0 = Address; c0 = FetchCount;
        Flush = 1'b1;
        tick();
        n_cmp++;
        if (IFID_Valid !== 1'b0 || Address !== a0 + 64'd4 || FetchCount !== c0) begin
            n_fail++;
            $display("FAIL flush_advance: v=%b addr=%h cnt=%0d, need 0 %h %0d",
                     IFID_Valid, Address, FetchCount, a0 + 64'd4, c0);
        end
        Stall = 1'b1;
        tick();
        n_cmp++;
        if (IFID_Valid !== 1'b0 || Address !== a0 + 64'd4) begin
            n_fail++;
            $display("FAIL flush_stall: v=%b addr=%h, need 0 %h", IFID_Valid, Address, a0 + 64'd4);
        end
        Flush = 1'b0; Stall = 1'b0;
    endtask

    task automatic test_wrap();
        mem[255] = 32'h5A5A_00FF;
        BranchTaken = 1'b1; BranchTarget = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        BranchTaken = 1'b0;
        tick();
        n_cmp++;
        if (Address !== 64'h0 || IFID_PC !== 64'hFFFF_FFFF_FFFF_FFFC ||
            IFID_Instruction !== 32'h5A5A_00FF || IFID_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pc_wrap: addr=%h pc=%h ins=%h v=%b, need 0 fffffffffffffffc 5a5a00ff 1",
                     Address, IFID_PC, IFID_Instruction, IFID_Valid);
        end
    endtask

    task automatic test_halt();
        mem[4] = HALT;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (IFID_Instruction !== HALT || IFID_Valid !== 1'b1 || IFID_PC !== 64'h10 ||
            Halted !== 1'b1 || Address !== 64'h10 || FetchCount !== 32'd5) begin
            n_fail++;
            $display("FAIL halt_latch: ins=%h v=%b pc=%h h=%b addr=%h cnt=%0d, need d4400000 1 10 1 10 5",
                     IFID_Instruction, IFID_Valid, IFID_PC, Halted, Address, FetchCount);
        end
        for (int i = 0; i < 3; i++) begin
            Stall = i[0]; Flush = ~i[0];
            tick();
            n_cmp++;
            if (Halted !== 1'b1 || IFID_Valid !== 1'b0 || Address !== 64'h10 ||
                FetchCount !== 32'd5) begin
                n_fail++;
                $display("FAIL halt_frozen[%0d]: h=%b v=%b addr=%h cnt=%0d, need 1 0 10 5",
                         i, Halted, IFID_Valid, Address, FetchCount);
            end
        end
        Stall = 1'b1; Flush = 1'b1; BranchTaken = 1'b1; BranchTarget = 64'h0;
        tick();
        Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0;
        n_cmp++;
        if (Halted !== 1'b0 || Address !== 64'h0 || IFID_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exit: h=%b addr=%h v=%b, need 0 0 0", Halted, Address, IFID_Valid);
        end
        tick();
        n_cmp++;
        if (IFID_Valid !== 1'b1 || IFID_PC !== 64'h0 || Address !== 64'h4) begin
            n_fail++;
            $display("FAIL halt_resume: v=%b pc=%h addr=%h, need 1 0 4", IFID_Valid, IFID_PC, Address);
        end
    endtask

    task automatic test_async_reset_halt();
        // From PC=4 the halt word at 0x10 is reached after four fetches.
        for (int i = 0; i < 5; i++) tick();
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 64'h43;
        #2;
        RESET_N = 1'b0;
        #1;
        n_cmp++;
        if (Address !== 64'h0 || IFID_Valid !== 1'b0 || IFID_PC !== 64'h0 ||
            IFID_Instruction !== 32'h0 || Halted !== 1'b0 || MisalignErr !== 1'b0 ||
            FetchCount !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: addr=%h v=%b pc=%h ins=%h h=%b m=%b cnt=%0d, need all zero",
                     Address, IFID_Valid, IFID_PC, IFID_Instruction, Halted, MisalignErr, FetchCount);
        end
        tick();
        n_cmp++;
        if (Address !== 64'h0 || MisalignErr !== 1'b0 || Halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_override: addr=%h m=%b h=%b, need 0 0 0", Address, MisalignErr, Halted);
        end
        Stall = 1'b0; BranchTaken = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] m_pc, m_ifpc;
        logic [31:0] m_instr, m_cnt, w;
        logic        m_valid, m_mis;
        int          m_mode;   // 0 boot, 1 run, 2 halt
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
        do_reset();
        m_pc = 0; m_ifpc = 0; m_instr = 0; m_cnt = 0; m_valid = 0; m_mis = 0; m_mode = 0;
        for (int c = 0; c < 600; c++) begin
            Stall       = ($urandom_range(0, 3) == 0);
            Flush       = ($urandom_range(0, 7) == 0);
            BranchTaken = ($urandom_range(0, 7) == 0);
            BranchTarget = ($urandom_range(0, 15) == 0) ? {32'hFFFF_FFFF, $urandom} :
                                                          64'($urandom_range(0, 1023));
            w = mem[m_pc[9:2]];
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (BranchTaken) begin
                m_pc = BranchTarget - 64'(BranchTarget % 4);
                m_valid = 0;
                if (BranchTarget % 4 != 0) m_mis = 1;
                m_mode = 1;
            end else if (m_mode == 2) begin
                m_valid = 0;
            end else if (Flush) begin
                m_valid = 0;
                if (!Stall) m_pc = m_pc + 4;
            end else if (!Stall) begin
                m_ifpc = m_pc; m_instr = w; m_valid = 1; m_cnt = m_cnt + 1;
                if (w == HALT) m_mode = 2;
                else m_pc = m_pc + 4;
            end
            tick();
            n_cmp++;
            if (Address !== m_pc || IFID_Valid !== m_valid || Halted !== (m_mode == 2) ||
                MisalignErr !== m_mis || FetchCount !== m_cnt ||
                (m_valid && (IFID_PC !== m_ifpc || IFID_Instruction !== m_instr))) begin
                n_fail++;
                $display("FAIL random[%0d]: addr=%h v=%b h=%b m=%b cnt=%0d pc=%h ins=%h, need %h %b %b %b %0d %h %h",
                         c, Address, IFID_Valid, Halted, MisalignErr, FetchCount, IFID_PC,
                         IFID_Instruction, m_pc, m_valid, (m_mode == 2), m_mis, m_cnt, m_ifpc, m_instr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_misalign();
        test_flush();
        test_wrap();
        test_halt();
        test_async_reset_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_ENC, default 32'hD4400000, meaning the instruction encoding that stops fetch.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 Stall  input  1  hazard stall: hold the PC and the IF/ID register.
REQ-006 Flush  input  1  invalidate the IF/ID register on the next edge.
REQ-007 BranchTaken  input  1  redirect fetch this cycle.
REQ-008 BranchTarget  input  64  redirect address.
REQ-009 Instruction  input  32  combinational read data returned for Address.
REQ-010 Address  output  64  current PC, driven to instruction memory.
REQ-011 IFID_PC  output  64  PC of the latched instruction.
REQ-012 IFID_Instruction  output  32  latched instruction.
REQ-013 IFID_Valid  output  1  latched instruction is live.
REQ-014 Halted  output  1  fetch is stopped on HALT_ENC.
REQ-015 MisalignErr  output  1  sticky flag: a redirect target had bits [1:0] nonzero.
REQ-016 FetchCount  output  32  count of instructions latched with IFID_Valid=1.

Function
REQ-017 Address SHALL equal the PC register combinationally, with zero-cycle lookup through instruction memory.
REQ-018 FSM states SHALL be BOOT, RUN and HALT; reset enters BOOT.
REQ-019 In BOOT, IFID_Valid SHALL stay 0 and the PC SHALL hold for one cycle, then the FSM SHALL move to RUN.
REQ-020 Per-edge priority in RUN SHALL be, highest first: BranchTaken, Flush, Stall, normal advance.
REQ-021 On BranchTaken, the PC SHALL load {BranchTarget[63:2],2'b00} and IFID_Valid SHALL become 0, regardless of Stall.
REQ-022 On BranchTaken with BranchTarget[1:0]!=0, MisalignErr SHALL set and remain set until reset.
REQ-023 On Flush without BranchTaken, IFID_Valid SHALL become 0 and the PC SHALL advance by 4 unless Stall=1.
REQ-024 On Stall alone, the PC, IFID_PC, IFID_Instruction and IFID_Valid SHALL hold.
REQ-025 On normal advance, IFID_PC SHALL load the PC, IFID_Instruction SHALL load Instruction, IFID_Valid SHALL become 1, and the PC SHALL load PC+4.
REQ-026 PC arithmetic SHALL be 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 SHALL wrap to 0.
REQ-027 On normal advance with Instruction==HALT_ENC, the instruction SHALL latch with IFID_Valid=1, the PC SHALL hold, and the FSM SHALL enter HALT.
REQ-028 In HALT, Halted=1, IFID_Valid SHALL become 0 on the next edge, and the PC SHALL be frozen.
REQ-029 In HALT, only BranchTaken SHALL exit, per REQ-021, to RUN; Stall and Flush SHALL be ignored.
REQ-030 FetchCount SHALL increment by 1 on each edge that latches IFID_Valid=1, and SHALL wrap at 2^32.

Reset
REQ-031 RESET_N=0 SHALL asynchronously set PC=RESET_PC, IFID_PC=0, IFID_Instruction=0, IFID_Valid=0, Halted=0, MisalignErr=0, FetchCount=0 and state=BOOT.
REQ-032 Reset asserted mid-stall, mid-branch or in HALT SHALL override all inputs.
REQ-033 The first edge after deassertion SHALL be the BOOT cycle.

Structure
REQ-034 A shared package arm_pkg SHALL hold INSTR_W=32, ADDR_W=64, PC_INC=4, HALT_ENC and the fetch-state enumeration.
REQ-035 The IF/ID register SHALL be the sub-module ifid_reg, with load, clear and hold controls; the PC and FSM SHALL live in if_stage.

Verification
REQ-036 Reset with RESET_PC=0 and memory words 0..3 = A,B,C,D -> Address 0,0,4,8,12 on successive cycles; IFID_Valid 0,0,1,1 with IFID_Instruction=A at Address=4.
REQ-037 Stall=1 for 2 cycles at PC=8 -> Address stays 8; IFID holds PC=4 and instruction B; FetchCount unchanged.
REQ-038 BranchTaken=1 with Stall=1 and BranchTarget=0x40 -> next Address=0x40 and IFID_Valid=0; the following cycle latches PC=0x40.
REQ-039 BranchTarget=0x43 -> Address=0x40 and MisalignErr=1, which stays 1 through 10 further cycles.
REQ-040 Memory word at 0x10 = 32'hD4400000 -> IFID latches it with Valid=1; then Halted=1, Valid=0 and Address stays 0x10; a later branch to 0 resumes RUN.
REQ-041 RESET_N dropped asynchronously mid-cycle in HALT -> all outputs take reset values before the next edge.
